mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Sequences the single byte-wide RAM port between two requesters: instruction fetch (IF, 32-bit reads)
//  and the MEM stage (loads/stores of byte, half or word). Breaks every access into byte beats,
//  assembles and sign/zero-extends load data, and returns a one-cycle done pulse to the winning requester.
//  Sits between the IF/MEM stages and the RAM port.
// PARAMETERS
//  ADDR_W     32  RAM and requester address width; byte address k+1 wraps mod 2^ADDR_W
//  MEM_FIRST  1   1: MEM wins simultaneous requests; 0: IF wins
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  rst           in   1       reset, synchronous, active-high
//  rdy           in   1       global ready; 0 freezes the controller
//  if_req_i      in   1       IF requests a 4-byte read; level, held until if_done_o
//  if_addr_i     in   ADDR_W  IF byte address
//  if_flush_i    in   1       abort in-flight/pending IF read (branch redirect)
//  if_done_o     out  1       1-cycle pulse: if_rdata_o valid
//  if_rdata_o    out  32      fetched word, little-endian
//  mem_req_i     in   1       MEM requests an access; level, held until mem_done_o
//  mem_we_i      in   1       1 store, 0 load
//  mem_size_i    in   2       00 byte, 01 half, 10 word (11 treated as word)
//  mem_signed_i  in   1       load sign-extend (1) / zero-extend (0)
//  mem_addr_i    in   ADDR_W  MEM byte address (any alignment)
//  mem_wdata_i   in   32      store data, low N bytes used
//  mem_done_o    out  1       1-cycle pulse: access complete, mem_rdata_o valid for loads
//  mem_rdata_o   out  32      extended load result
//  ram_din_i     in   8       RAM read byte; valid the cycle after its address is driven
//  ram_a_o       out  ADDR_W  RAM byte address (registered)
//  ram_dout_o    out  8       RAM write byte (registered)
//  ram_wr_o      out  1       RAM write strobe (registered)
// BEHAVIOUR
//  Reset: state IDLE, beat counter 0; all outputs 0. Reset mid-transaction aborts it: ram_wr_o=0 the
//   cycle after, no done pulse.
//  States: IDLE, IF_RD, MEM_RD, MEM_WR. N = bytes (IF: 4; MEM: 1/2/4 from mem_size_i).
//  Accept (cycle A, state IDLE, rdy=1): arbitrate per MEM_FIRST; latch addr/size/signed/wdata;
//   ram_a_o<=addr; counter<=0. No accept in a cycle where if_done_o or mem_done_o is 1.
//  Read: addr+k driven in cycles A+1..A+N; byte k sampled from ram_din_i in cycle A+k+2 into lane k;
//   done pulse + data in cycle A+N+2 (LW/IF: A+6, LB: A+3); state IDLE in that same cycle.
//  Write: cycles A+1..A+N drive ram_a_o=addr+k, ram_dout_o=wdata byte k, ram_wr_o=1; mem_done_o in A+N+1
//   with ram_wr_o=0.
//  Load extension: bit 8N-1 replicated into [31:8N] if mem_signed_i, else zeros. Word ignores sign.
//  rdo/data outputs hold last value between pulses; done pulses are exactly 1 cycle (rdy=1).
//  rdy=0: every register holds (state, counter, ram_a_o, lanes); ram_wr_o forced 0; ram_din_i and all
//   requester inputs, including if_flush_i, ignored. Resume continues exactly where it froze.
//  if_flush_i=1 (rdy=1): any IF_RD transaction aborts -> IDLE next cycle, no if_done_o; in IDLE, the IF
//   request in the same cycle is not accepted. MEM transactions unaffected. A done pulse already
//   visible in the flush cycle is not retracted.
//  No preemption: a started transaction always completes (except reset/flush of IF).
//  Idle ram_a_o keeps its last value; ram_wr_o=0 outside write beats.
// TESTING
//  1 RAM[0x100..0x103]=11,22,33,44; mem LW @0x100 accepted cycle A -> mem_done_o in A+6, rdata=0x44332211.
//  2 RAM[0x10]=0x80: LB -> 0xFFFFFF80, LBU -> 0x00000080; RAM[0x20..21]=01,80 LH -> 0xFFFF8001, done A+4.
//  3 SH @0x203 wdata=0xDEADBEEF -> ram_wr_o 2 cycles: (0x203,EF),(0x204,BE); done A+3; 0x205 untouched.
//  4 if_req & mem_req same cycle, MEM_FIRST=1 -> MEM served first; IF accepted cycle after mem_done_o,
//    if_done_o 6 cycles later; MEM_FIRST=0 reverses order.
//  5 if_flush_i at A+3 of IF read -> no if_done_o, IDLE at A+4; new if_req @0x0 completes with correct word.
//  6 rdy=0 for 3 cycles mid-LW -> same rdata, done at A+9; rst at A+2 of SW -> ram_wr_o=0 next cycle,
//    no mem_done_o, all outputs 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM sequencer shared by instruction fetch and the MEM stage.
// Every access is split into byte beats on a single 8-bit RAM port. Load bytes are
// gathered little-endian and then sign/zero-extended. The winning requester gets a
// one-cycle done pulse.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a request; arbitration happens here
//   S_IF_RD  | 4-byte instruction read in progress (abortable by flush)
//   S_MEM_RD | MEM load of 1/2/4 bytes in progress
//   S_MEM_WR | MEM store of 1/2/4 bytes in progress, one write beat per cycle
module mem_ctrl #(
  parameter int ADDR_W    = 32,
  parameter bit MEM_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_signed_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IF_RD  = 2'd1;
  localparam logic [1:0] S_MEM_RD = 2'd2;
  localparam logic [1:0] S_MEM_WR = 2'd3;

  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic        sgn_q;
  logic [31:0] wdata_q;
  logic [31:0] lanes;
  logic        wr_q;

  logic [2:0]  cnt_inc;
  logic [31:0] lanes_nxt;
  logic [7:0]  wbyte_nxt;
  logic        if_ok;
  logic        pick_mem;
  logic        pick_if;
  logic        done_busy;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n, input logic s);
    case (n)
      3'd1:    return {{24{s & w[7]}}, w[7:0]};
      3'd2:    return {{16{s & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Read data lags its address by one cycle, so the byte landing now belongs to lane cnt-1.
  always_comb begin
    lanes_nxt = lanes;
    case (cnt)
      3'd1:    lanes_nxt[7:0]   = ram_din_i;
      3'd2:    lanes_nxt[15:8]  = ram_din_i;
      3'd3:    lanes_nxt[23:16] = ram_din_i;
      3'd4:    lanes_nxt[31:24] = ram_din_i;
      default: lanes_nxt = lanes;
    endcase
  end

  // Next store byte and arbitration; a flush makes the IF request ineligible this cycle.
  always_comb begin
    cnt_inc = cnt + 3'd1;
    case (cnt)
      3'd0:    wbyte_nxt = wdata_q[15:8];
      3'd1:    wbyte_nxt = wdata_q[23:16];
      default: wbyte_nxt = wdata_q[31:24];
    endcase
    if_ok     = if_req_i & ~if_flush_i;
    pick_mem  = mem_req_i & (MEM_FIRST | ~if_ok);
    pick_if   = if_ok & ~pick_mem;
    done_busy = if_done_o | mem_done_o;
  end

  // Write strobe is dropped immediately while the controller is frozen.
  assign ram_wr_o = wr_q & rdy;

  // Main sequencer; rdy=0 freezes every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      nbytes      <= 3'd0;
      sgn_q       <= 1'b0;
      wdata_q     <= 32'd0;
      lanes       <= 32'd0;
      wr_q        <= 1'b0;
      ram_a_o     <= '0;
      ram_dout_o  <= 8'd0;
      if_done_o   <= 1'b0;
      if_rdata_o  <= 32'd0;
      mem_done_o  <= 1'b0;
      mem_rdata_o <= 32'd0;
    end else if (rdy) begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!done_busy && pick_mem) begin
            state   <= mem_we_i ? S_MEM_WR : S_MEM_RD;
            ram_a_o <= mem_addr_i;
            cnt     <= 3'd0;
            nbytes  <= size_bytes(mem_size_i);
            sgn_q   <= mem_signed_i;
            wdata_q <= mem_wdata_i;
            if (mem_we_i) begin
              ram_dout_o <= mem_wdata_i[7:0];
              wr_q       <= 1'b1;
            end
          end else if (!done_busy && pick_if) begin
            state   <= S_IF_RD;
            ram_a_o <= if_addr_i;
            cnt     <= 3'd0;
            nbytes  <= 3'd4;
            sgn_q   <= 1'b0;
          end
        end
        S_IF_RD, S_MEM_RD: begin
          if (state == S_IF_RD && if_flush_i) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc < nbytes)
              ram_a_o <= ram_a_o + A_ONE;
            if (cnt != 3'd0)
              lanes <= lanes_nxt;
            if (cnt == nbytes) begin
              state <= S_IDLE;
              cnt   <= 3'd0;
              if (state == S_IF_RD) begin
                if_done_o  <= 1'b1;
                if_rdata_o <= lanes_nxt;
              end else begin
                mem_done_o  <= 1'b1;
                mem_rdata_o <= extend(lanes_nxt, nbytes, sgn_q);
              end
            end
          end
        end
        S_MEM_WR: begin
          if (cnt_inc < nbytes) begin
            ram_a_o    <= ram_a_o + A_ONE;
            ram_dout_o <= wbyte_nxt;
            wr_q       <= 1'b1;
            cnt        <= cnt_inc;
          end else begin
            wr_q       <= 1'b0;
            mem_done_o <= 1'b1;
            state      <= S_IDLE;
            cnt        <= 3'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
